// File: rtl/matriz_pkg.sv
// Shared types and helpers for the snake LED-matrix renderer.
//   state_e      : renderer FSM states
//   cell_to_led  : playfield cell index -> LED bit index (row-major, inside the border ring)
//   border_mask  : LED bits forming the outer ring of a (grid_w+2) x (grid_h+2) matrix
package matriz_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StCommit
  } state_e;

  // Upper bound on matrix size handled by border_mask; callers truncate to their LED width.
  localparam int unsigned MaxLedW = 4096;

  function automatic int unsigned cell_to_led(int unsigned p, int unsigned grid_w);
    return (p / grid_w + 1) * (grid_w + 2) + (p % grid_w) + 1;
  endfunction

  function automatic logic [MaxLedW-1:0] border_mask(int unsigned grid_w, int unsigned grid_h);
    logic [MaxLedW-1:0] m;
    m = '0;
    for (int unsigned r = 0; r < grid_h + 2; r++) begin
      for (int unsigned c = 0; c < grid_w + 2; c++) begin
        if (r == 0 || r == grid_h + 1 || c == 0 || c == grid_w + 1) begin
          m = m | (MaxLedW'(1) << (r * (grid_w + 2) + c));
        end
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/blink_divider.sv
// Free-running blink phase generator.
//   clock       : system clock, rising edge
//   reset       : asynchronous, active-high
//   blink_phase : toggles every BLINK_DIV clock cycles (counter wraps 0..BLINK_DIV-1)
module blink_divider #(
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic clock,
  input  logic reset,
  output logic blink_phase
);

  localparam int unsigned CntW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + CntW'(1);
    phase_d = phase_q;
    if (cnt_q == CntW'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink_phase = phase_q;

endmodule

// File: rtl/matriz_leds_render.sv
// LED-matrix renderer for the snake game. A refresh snapshots the game state, scans the
// playfield one cell per cycle into a shadow buffer, then commits the frame to leds at once.
//   clock, reset : system clock (rising edge), asynchronous active-high reset
//   refresh      : single-cycle frame request (collapses into one pending request while busy)
//   body_mask    : bit p set = snake occupies playfield cell p
//   apple        : apple cell index; apple_valid : apple present
//   game_over    : game ended (border flashes, apple hidden)
//   leds         : registered image, bit index = row*(GRID_W+2)+col
//   frame_done   : one-cycle pulse in the cycle after leds updates
//   busy         : high while scanning or committing
module matriz_leds_render
  import matriz_pkg::*;
#(
  parameter  int unsigned GRID_W    = 4,
  parameter  int unsigned GRID_H    = 4,
  parameter  int unsigned BLINK_DIV = 25000000,
  localparam int unsigned N         = GRID_W * GRID_H,
  localparam int unsigned POS_W     = $clog2(N),
  localparam int unsigned LED_W     = (GRID_W + 2) * (GRID_H + 2)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             refresh,
  input  logic [N-1:0]     body_mask,
  input  logic [POS_W-1:0] apple,
  input  logic             apple_valid,
  input  logic             game_over,
  output logic [LED_W-1:0] leds,
  output logic             frame_done,
  output logic             busy
);

  localparam logic [LED_W-1:0] BorderMask = LED_W'(border_mask(GRID_W, GRID_H));

  state_e             state_q, state_d;
  logic [POS_W-1:0]   cnt_q, cnt_d;
  logic               pending_q, pending_d;
  logic [N-1:0]       body_snap_q, body_snap_d;
  logic [POS_W-1:0]   apple_snap_q, apple_snap_d;
  logic               apple_valid_snap_q, apple_valid_snap_d;
  logic               game_over_snap_q, game_over_snap_d;
  logic               blink_snap_q, blink_snap_d;
  logic [N-1:0]       shadow_q, shadow_d;
  logic [LED_W-1:0]   leds_q, leds_d;
  logic               frame_done_q, frame_done_d;
  logic               blink_phase;
  logic [LED_W-1:0]   interior_img;
  logic               border_on;

  blink_divider #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clock       (clock),
    .reset       (reset),
    .blink_phase (blink_phase)
  );

  // Scatter the shadow buffer onto the interior LED positions; ring positions stay 0 here
  // and get the border pattern separately at commit time.
  for (genvar i = 0; i < LED_W; i++) begin : g_ring
    if (BorderMask[i]) begin : g_zero
      assign interior_img[i] = 1'b0;
    end
  end

  for (genvar p = 0; p < N; p++) begin : g_cell
    assign interior_img[cell_to_led(p, GRID_W)] = shadow_q[p];
  end

  // Border is dark only during the off-phase of a game-over flash.
  assign border_on = ~game_over_snap_q | blink_snap_q;

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    pending_d          = pending_q;
    body_snap_d        = body_snap_q;
    apple_snap_d       = apple_snap_q;
    apple_valid_snap_d = apple_valid_snap_q;
    game_over_snap_d   = game_over_snap_q;
    blink_snap_d       = blink_snap_q;
    shadow_d           = shadow_q;
    leds_d             = leds_q;
    frame_done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (refresh || pending_q) begin
          body_snap_d        = body_mask;
          apple_snap_d       = apple;
          apple_valid_snap_d = apple_valid;
          game_over_snap_d   = game_over;
          blink_snap_d       = blink_phase;
          cnt_d              = '0;
          pending_d          = 1'b0;
          state_d            = StScan;
        end
      end
      StScan: begin
        // An out-of-range apple index never equals a scanned cell, so nothing is lit for it.
        shadow_d[cnt_q] = body_snap_q[cnt_q] |
                          (apple_valid_snap_q & ~game_over_snap_q & blink_snap_q &
                           (apple_snap_q == cnt_q));
        if (cnt_q == POS_W'(N - 1)) begin
          state_d = StCommit;
        end else begin
          cnt_d = cnt_q + POS_W'(1);
        end
        if (refresh) begin
          pending_d = 1'b1;
        end
      end
      StCommit: begin
        leds_d       = (border_on ? BorderMask : '0) | interior_img;
        frame_done_d = 1'b1;
        state_d      = StIdle;
        if (refresh) begin
          pending_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q            <= StIdle;
      cnt_q              <= '0;
      pending_q          <= 1'b0;
      body_snap_q        <= '0;
      apple_snap_q       <= '0;
      apple_valid_snap_q <= 1'b0;
      game_over_snap_q   <= 1'b0;
      blink_snap_q       <= 1'b0;
      shadow_q           <= '0;
      leds_q             <= BorderMask;
      frame_done_q       <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      pending_q          <= pending_d;
      body_snap_q        <= body_snap_d;
      apple_snap_q       <= apple_snap_d;
      apple_valid_snap_q <= apple_valid_snap_d;
      game_over_snap_q   <= game_over_snap_d;
      blink_snap_q       <= blink_snap_d;
      shadow_q           <= shadow_d;
      leds_q             <= leds_d;
      frame_done_q       <= frame_done_d;
    end
  end

  assign leds       = leds_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_matriz_leds_render.sv
// Self-checking bench for matriz_leds_render (4x4 playfield, BLINK_DIV=4).
module tb_matriz_leds_render;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int LW = (W + 2) * (H + 2);
  localparam int BD = 4;

  localparam logic [35:0] B = 36'hFE186187F;

  logic          clock;
  logic          reset;
  logic          refresh;
  logic [N-1:0]  body_mask;
  logic [3:0]    apple;
  logic          apple_valid;
  logic          game_over;
  logic [LW-1:0] leds;
  logic          frame_done;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 0;

  matriz_leds_render #(
    .GRID_W    (W),
    .GRID_H    (H),
    .BLINK_DIV (BD)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .refresh     (refresh),
    .body_mask   (body_mask),
    .apple       (apple),
    .apple_valid (apple_valid),
    .game_over   (game_over),
    .leds        (leds),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Image straight from the rendering rules: ring lit unless game over in phase 0,
  // a cell lit if body covers it or the visible apple sits on it.
  function automatic logic [35:0] render(input logic [15:0] body, input int ap, input bit av,
                                         input bit go, input bit ph);
    logic [35:0] r;
    r = '0;
    for (int row = 0; row < H + 2; row++) begin
      for (int col = 0; col < W + 2; col++) begin
        if ((row == 0 || row == H + 1 || col == 0 || col == W + 1) && (!go || ph)) begin
          r = r | (36'd1 << (row * (W + 2) + col));
        end
      end
    end
    for (int p = 0; p < N; p++) begin
      if (body[p] || (av && !go && ph && ap == p)) begin
        r = r | (36'd1 << ((p / W + 1) * (W + 2) + (p % W) + 1));
      end
    end
    return r;
  endfunction

  // Timeline model: edges counted from reset release; a frame sampled at edge S commits
  // at edge S+N+1; requests seen while a frame is in flight collapse into one follow-up.
  int          m_j;
  bit          m_active;
  int          m_start;
  bit          m_pend;
  logic [15:0] s_body;
  int          s_apple;
  bit          s_av, s_go, s_ph;
  logic [35:0] m_leds;
  bit          m_done, m_busy;

  initial begin
    m_j = 0; m_active = 0; m_start = 0; m_pend = 0;
    m_leds = render(16'h0, 0, 0, 0, 1); m_done = 0; m_busy = 0;
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_j = 0; m_active = 0; m_pend = 0;
        m_leds = render(16'h0, 0, 0, 0, 1); m_done = 0; m_busy = 0;
      end else begin
        m_j++;
        m_done = 0;
        if (m_active) begin
          if (refresh) m_pend = 1;
          if (m_j == m_start + N + 1) begin
            m_leds   = render(s_body, s_apple, s_av, s_go, s_ph);
            m_done   = 1;
            m_active = 0;
          end
        end else if (refresh || m_pend) begin
          s_body   = body_mask;
          s_apple  = int'(apple);
          s_av     = apple_valid;
          s_go     = game_over;
          s_ph     = ((m_j - 1) / BD) % 2 == 1;
          m_start  = m_j;
          m_pend   = 0;
          m_active = 1;
        end
        m_busy = m_active;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (check_en) begin
        chk("cyc_leds", leds, m_leds);
        chk("cyc_frame_done", 36'(frame_done), 36'(m_done));
        chk("cyc_busy", 36'(busy), 36'(m_busy));
      end
    end
  end

  // One frame with literal expectations; ph < 0 means the blink phase does not matter.
  task automatic run_frame(input logic [15:0] body, input logic [3:0] ap, input bit av,
                           input bit go, input int ph, input logic [35:0] exp,
                           input string name);
    int busy_cnt;
    int guard;
    @(posedge clock); #2;
    body_mask = body; apple = ap; apple_valid = av; game_over = go;
    guard = 0;
    while (ph >= 0 && ((m_j / BD) % 2) != ph && guard < 4 * BD) begin
      @(posedge clock); #2;
      guard++;
    end
    if (guard >= 4 * BD) begin
      n_tests++; n_fail++;
      $display("FAIL %s_phase_wait: blink phase %0d never reached", name, ph);
    end
    refresh = 1'b1;
    @(posedge clock); #2;
    refresh = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < N + 1; i++) begin
      @(negedge clock);
      if (busy) busy_cnt++;
    end
    @(negedge clock);
    chk({name, "_leds"}, leds, exp);
    chk({name, "_done"}, 36'(frame_done), 36'd1);
    chk({name, "_busy_cycles"}, 36'(busy_cnt), 36'd17);
    @(negedge clock);
    chk({name, "_done_clear"}, 36'(frame_done), 36'd0);
  endtask

  initial begin
    int          nframes;
    logic [35:0] frames [2];
    reset = 1'b1; refresh = 1'b0; body_mask = '0; apple = '0;
    apple_valid = 1'b0; game_over = 1'b0;
    frames[0] = '0; frames[1] = '0;
    repeat (3) @(posedge clock);
    #2 check_en = 1'b1;
    @(posedge clock); #2 reset = 1'b0;

    // Idle after reset: border only, no activity.
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("idle_leds", leds, B);
      chk("idle_done", 36'(frame_done), 36'd0);
      chk("idle_busy", 36'(busy), 36'd0);
    end

    run_frame(16'h0001, 4'd0, 1'b0, 1'b0, -1, 36'hFE18618FF, "body_cell0");
    run_frame(16'h0001, 4'd5, 1'b1, 1'b0, 1, 36'hFE18658FF, "apple_on");
    run_frame(16'h0001, 4'd5, 1'b1, 1'b0, 0, 36'hFE18618FF, "apple_off");
    run_frame(16'h0001, 4'd5, 1'b1, 1'b0, 1, 36'hFE18658FF, "apple_on2");
    run_frame(16'h0000, 4'd0, 1'b0, 1'b0, -1, B, "cleared");
    run_frame(16'h8000, 4'd0, 1'b0, 1'b1, 0, 36'h010000000, "gameover_ph0");
    run_frame(16'h8000, 4'd0, 1'b0, 1'b1, 1, 36'hFF186187F, "gameover_ph1");
    run_frame(16'h8000, 4'd5, 1'b1, 1'b1, 1, 36'hFF186187F, "gameover_apple");
    run_frame(16'h0001, 4'd0, 1'b1, 1'b0, 1, 36'hFE18618FF, "apple_on_body");

    // Three requests during one scan, body changed mid-scan.
    @(posedge clock); #2;
    body_mask = 16'h0001; apple_valid = 1'b0; game_over = 1'b0; refresh = 1'b1;
    @(posedge clock); #2 refresh = 1'b0;
    repeat (3) @(posedge clock);
    #2 refresh = 1'b1;
    @(posedge clock); #2 refresh = 1'b0; body_mask = 16'h8000;
    repeat (3) @(posedge clock);
    #2 refresh = 1'b1;
    @(posedge clock); #2 refresh = 1'b0;
    nframes = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (frame_done) begin
        if (nframes < 2) frames[nframes] = leds;
        nframes++;
      end
    end
    chk("pending_frames", 36'(nframes), 36'd2);
    chk("pending_first_old_snap", frames[0], 36'hFE18618FF);
    chk("pending_second_new_snap", frames[1], 36'hFF186187F);

    // Reset in the middle of a scan aborts it.
    @(posedge clock); #2;
    body_mask = 16'h0001; refresh = 1'b1;
    @(posedge clock); #2 refresh = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    chk("abort_leds_in_reset", leds, B);
    @(posedge clock); #2 reset = 1'b0;
    nframes = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (frame_done) nframes++;
    end
    chk("abort_no_frame", 36'(nframes), 36'd0);
    chk("abort_leds", leds, B);
    chk("abort_busy", 36'(busy), 36'd0);

    repeat (2) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_tests++; n_fail++;
    $display("FAIL watchdog: bench did not complete, time %0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matriz_leds_render.md
Name: matriz_leds_render

Overview:
- Parametrised LED-matrix renderer for the snake game.
- Drives a (GRID_W+2)x(GRID_H+2) LED matrix: fixed border ring around a GRID_W x GRID_H playfield.
- On each refresh request it snapshots the game core's body occupancy, apple position and game-over flag, scans the playfield one cell per cycle into a shadow buffer, then commits the whole frame atomically.
- Adds a blinking apple and a flashing border on game over; cells are fully cleared each frame.

Parameters:
- GRID_W, 4, playfield columns (>=2)
- GRID_H, 4, playfield rows (>=2)
- BLINK_DIV, 25000000, clock cycles per blink-phase toggle (>=2)
- Derived, not overridable: N = GRID_W*GRID_H; POS_W = clog2(N); LED_W = (GRID_W+2)*(GRID_H+2)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- refresh  in  1  single-cycle frame request
- body_mask  in  N  bit p = snake occupies playfield cell p
- apple  in  POS_W  apple cell index
- apple_valid  in  1  apple present
- game_over  in  1  game ended
- leds  out  LED_W  registered matrix image, bit index = row*(GRID_W+2)+col
- frame_done  out  1  one-cycle pulse when leds is updated
- busy  out  1  high while in SCAN or COMMIT

Behaviour:
- Mapping: playfield cell p has r = p/GRID_W, c = p%GRID_W and lights LED (r+1)*(GRID_W+2)+(c+1).
- Border = all LEDs in row 0, row GRID_H+1, col 0 and col GRID_W+1.
- Reset values (asynchronous):
  - leds = border lit, interior 0 (4x4: 36'hFE186187F)
  - frame_done = 0, busy = 0
  - FSM in IDLE
  - cell counter, blink counter, blink_phase and pending all 0
  - Reset asserted mid-scan aborts the scan immediately; the partial shadow buffer is never committed.
- Blink counter: free-runs 0..BLINK_DIV-1 in every state. blink_phase toggles on wrap.
- FSM states:
  - IDLE: on refresh=1, snapshot body_mask, apple, apple_valid, game_over and the current blink_phase; clear cell counter; go to SCAN.
  - SCAN: one cell per cycle, cell k handled in the k-th SCAN cycle (k=0..N-1).
    - Playfield cell lit = body_snap[k] | (apple_valid_snap & ~game_over_snap & blink_snap & apple_snap==k).
    - After cell N-1, go to COMMIT.
  - COMMIT: border bits = ~game_over_snap | blink_snap; all interior bits taken from the shadow buffer.
    - leds loads on the edge leaving COMMIT; frame_done=1 for exactly that following cycle; then IDLE.
- Latency: refresh sampled at edge E. SCAN occupies edges E+1..E+N, COMMIT is E+N+1. New leds and frame_done are visible after edge E+N+1, i.e. N+1 cycles after sampling.
- busy is 1 from the cycle after refresh is sampled until leds updates.
- Refresh while busy: sets pending (not a counter; extra requests collapse). COMMIT then returns to IDLE, and IDLE immediately starts the next scan with fresh snapshots. pending clears when that scan starts. refresh in the COMMIT cycle also sets pending.
- Apple index >= N (non-power-of-two grids): no cell lit.
- Apple overlapping body: cell lit (OR).
- Inputs changing during SCAN have no effect on the current frame.
- Every interior bit is rewritten each commit; no stale cells persist.

Decomposition:
- Package matriz_pkg:
  - FSM state enum (IDLE, SCAN, COMMIT)
  - function cell_to_led(p, GRID_W) returning LED index
  - function border_mask(GRID_W, GRID_H) returning LED_W bits
- One sub-module, blink_divider: parameter BLINK_DIV; outputs blink_phase; reset to 0.
- Shadow buffer, snapshot registers and FSM stay in matriz_leds_render.

Test Plan (GRID_W=GRID_H=4, BLINK_DIV=4, N=16):
- Reset mid-run, deassert, no refresh -> leds=36'hFE186187F, frame_done and busy stay 0.
- body_mask=16'h0001, apple_valid=0, refresh pulse -> 17 cycles later leds = border | bit7, frame_done one cycle, busy high for 17 cycles.
- body_mask=16'h0001, apple=5, apple_valid=1, refresh on blink_phase=1 then on blink_phase=0:
  - first frame lights bits 7 and 14;
  - second frame lights bit 7 only.
- Previous frame lit bit 14, then body_mask=0, apple_valid=0 -> next frame = 36'hFE186187F (cell cleared).
- game_over=1, body_mask=16'h8000, refresh on phase 0 and phase 1:
  - phase 0 frame: leds = bit 28 only;
  - phase 1 frame: border | bit28.
- Refresh pulsed three times during one scan -> exactly two frame_done pulses total. Change body_mask mid-scan -> first frame uses the old snapshot, second frame the new one. Assert reset during SCAN -> leds returns to border and no frame_done occurs.
